// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared CPU datapath types used by the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [31:0]                 word_t;
    typedef logic [$clog2(NUM_REGS)-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        word_t    wdat;
    } rf_wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_rr_arbiter
// Description : Round-robin arbiter with one-hot grant; owns the rotating
//               pointer (last granted index).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    import rf_wb_arbiter_pkg::*;

    localparam int c_iw = $clog2(N);

    logic [c_iw-1:0] ptr_q, ptr_d;
    logic [N-1:0]    w_grant;
    logic [c_iw-1:0] w_idx;
    logic            w_found;

    // Search starts just after the last winner and wraps, so it never favours a fixed index.
    always_comb begin
        int j;
        j       = 0;
        w_grant = '0;
        w_idx   = ptr_q;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!w_found && req[j]) begin
                w_found    = 1'b1;
                w_grant[j] = 1'b1;
                w_idx      = j[c_iw-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && w_found) begin
            ptr_d = w_idx;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= c_iw'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = w_grant & {N{nRST}};

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin sharing of the register-file write port among NREQ
//               writeback sources, plus pending-write scoreboard for the issue
//               stage. Optional same-cycle forwarding: RF_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = $clog2(NUM_REGS),
    parameter int DW   = $bits(word_t)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_wsel,
    input  logic [NREQ*DW-1:0] req_wdat,
    output logic [NREQ-1:0]    req_ready,
    output logic             rf_WEN,
    output logic [AW-1:0]    rf_wsel,
    output logic [DW-1:0]    rf_wdat,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    rsel1,
    input  logic [AW-1:0]    rsel2,
    output logic             busy1,
    output logic             busy2,
    output logic             waw_busy
`ifdef RF_WB_BYPASS_EN
    ,
    output logic             byp_hit1,
    output logic             byp_hit2,
    output logic [DW-1:0]    byp_dat1,
    output logic [DW-1:0]    byp_dat2
`endif
);

    localparam int c_nreg = 1 << AW;

    logic [NREQ-1:0]   w_grant;
    logic [AW-1:0]     w_sel_wsel;
    logic [DW-1:0]     w_sel_wdat;
    logic              w_any_grant;

    logic              rf_wen_q,  rf_wen_d;
    logic [AW-1:0]     rf_wsel_q, rf_wsel_d;
    logic [DW-1:0]     rf_wdat_q, rf_wdat_d;
    logic [c_nreg-1:0] pending_q, pending_d;

    rf_wb_arbiter_rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .CLK   (CLK),
        .nRST  (nRST),
        .req   (req_valid),
        .en    (1'b1),
        .grant (w_grant)
    );

    assign req_ready   = w_grant;
    assign w_any_grant = |w_grant;

    always_comb begin
        w_sel_wsel = '0;
        w_sel_wdat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_wsel = req_wsel[i*AW +: AW];
                w_sel_wdat = req_wdat[i*DW +: DW];
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_comb begin
        rf_wen_d  = 1'b0;
        rf_wsel_d = rf_wsel_q;
        rf_wdat_d = rf_wdat_q;
        if (w_any_grant && (w_sel_wsel != '0)) begin
            rf_wen_d  = 1'b1;
            rf_wsel_d = w_sel_wsel;
            rf_wdat_d = w_sel_wdat;
        end
    end

    // Set after clear: a newly issued producer outranks the one retiring now.
    always_comb begin
        pending_d = pending_q;
        if (rf_wen_q && pending_q[rf_wsel_q]) begin
            pending_d[rf_wsel_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_wen_q  <= 1'b0;
            rf_wsel_q <= '0;
            rf_wdat_q <= '0;
            pending_q <= '0;
        end else begin
            rf_wen_q  <= rf_wen_d;
            rf_wsel_q <= rf_wsel_d;
            rf_wdat_q <= rf_wdat_d;
            pending_q <= pending_d;
        end
    end

    assign rf_WEN   = rf_wen_q;
    assign rf_wsel  = rf_wsel_q;
    assign rf_wdat  = rf_wdat_q;
    assign waw_busy = pending_q[issue_rd];

`ifdef RF_WB_BYPASS_EN
    assign byp_hit1 = rf_wen_q && (rf_wsel_q == rsel1) && (rsel1 != '0);
    assign byp_hit2 = rf_wen_q && (rf_wsel_q == rsel2) && (rsel2 != '0);
    assign byp_dat1 = rf_wdat_q;
    assign byp_dat2 = rf_wdat_q;
    assign busy1    = pending_q[rsel1] && !byp_hit1;
    assign busy2    = pending_q[rsel2] && !byp_hit2;
`else
    assign busy1    = pending_q[rsel1];
    assign busy2    = pending_q[rsel2];
`endif

    a_onehot_grant : assert property (@(posedge CLK) disable iff (!nRST)
        $onehot0(req_ready));

    // Re-issuing a register in the very cycle its write retires is the legal set-wins case.
    a_no_waw_issue : assert property (@(posedge CLK) disable iff (!nRST)
        !(issue_valid && waw_busy && !(rf_WEN && (rf_wsel == issue_rd))));

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter (NREQ=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_wsel;
    logic [NREQ*DW-1:0] req_wdat;
    logic [NREQ-1:0]    req_ready;
    logic             rf_WEN;
    logic [AW-1:0]    rf_wsel;
    logic [DW-1:0]    rf_wdat;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    rsel1;
    logic [AW-1:0]    rsel2;
    logic             busy1;
    logic             busy2;
    logic             waw_busy;

    logic [DW-1:0]    rf_model [32];
    int               n_vec = 0;
    int               n_err = 0;

    always #5 CLK = ~CLK;

    rf_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_wsel    (req_wsel),
        .req_wdat    (req_wdat),
        .req_ready   (req_ready),
        .rf_WEN      (rf_WEN),
        .rf_wsel     (rf_wsel),
        .rf_wdat     (rf_wdat),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rsel1       (rsel1),
        .rsel2       (rsel2),
        .busy1       (busy1),
        .busy2       (busy2),
        .waw_busy    (waw_busy)
    );

    // Register file commits on the negedge following the registered write.
    always @(negedge CLK) begin
        if (rf_WEN) rf_model[rf_wsel] <= rf_wdat;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_g [4];
        logic [4:0] exp_w [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_w[0] = 5'd1;   exp_w[1] = 5'd2;   exp_w[2] = 5'd3;   exp_w[3] = 5'd1;

        // Reset with every requester asking
        nRST        = 1'b0;
        req_valid   = 3'b111;
        req_wsel    = {5'd3, 5'd2, 5'd1};
        req_wdat    = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        issue_valid = 1'b0;
        issue_rd    = '0;
        rsel1       = 5'd7;
        rsel2       = 5'd9;
        repeat (3) tick();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_wen",   rf_WEN,    1'b0);
        chk("rst_busy1", busy1,     1'b0);
        chk("rst_busy2", busy2,     1'b0);

        // Round-robin with all valid
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", req_ready, exp_g[k]);
            tick();
            chk("rr_wen",  rf_WEN,  1'b1);
            chk("rr_wsel", rf_wsel, exp_w[k]);
            chk("rr_wdat", rf_wdat, 32'h0000_00A0 + 32'(exp_w[k]) - 32'd1);
        end

        // Single write from requester 1
        req_valid = 3'b010;
        req_wsel  = {5'd3, 5'd5, 5'd1};
        req_wdat  = {32'h0000_00A2, 32'hDEAD_BEEF, 32'h0000_00A0};
        #1;
        chk("single_ready", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        chk("single_wen",  rf_WEN,  1'b1);
        chk("single_wsel", rf_wsel, 5'd5);
        chk("single_wdat", rf_wdat, 32'hDEAD_BEEF);
        tick();
        chk("idle_wen",   rf_WEN,      1'b0);
        chk("idle_wsel",  rf_wsel,     5'd5);
        chk("rf_readback", rf_model[5], 32'hDEAD_BEEF);

        // Scoreboard set / clear
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_waw_pre", waw_busy, 1'b0);
        chk("sb_busy_pre", busy1,   1'b0);
        tick();
        issue_valid = 1'b0;
        chk("sb_busy_set", busy1, 1'b1);
        chk("sb_busy2",    busy2, 1'b0);
        req_valid = 3'b001;
        req_wsel  = {5'd3, 5'd5, 5'd7};
        req_wdat  = {32'h0000_00A2, 32'hDEAD_BEEF, 32'h0000_0077};
        #1;
        chk("sb_ready0", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        chk("sb_wen",       rf_WEN,  1'b1);
        chk("sb_wsel",      rf_wsel, 5'd7);
        chk("sb_busy_hold", busy1,   1'b1);
        tick();
        chk("sb_busy_clr", busy1,  1'b0);
        chk("sb_wen_off",  rf_WEN, 1'b0);

        // Re-issue in the retire cycle: set wins
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        tick();
        req_valid   = 3'b000;
        chk("sw_wen", rf_WEN, 1'b1);
        issue_valid = 1'b1;
        #1;
        chk("sw_waw", waw_busy, 1'b1);
        tick();
        issue_valid = 1'b0;
        chk("sw_busy_kept", busy1, 1'b1);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        tick();
        chk("sw_busy_clr", busy1, 1'b0);

        // x0 handling
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("x0_waw_issue", waw_busy, 1'b0);
        tick();
        issue_valid = 1'b0;
        rsel1       = 5'd0;
        #1;
        chk("x0_waw_after", waw_busy, 1'b0);
        chk("x0_busy1",     busy1,    1'b0);
        req_valid = 3'b100;
        req_wsel  = {5'd0, 5'd12, 5'd7};
        #1;
        chk("x0_ready2", req_ready, 3'b100);
        tick();
        req_valid = 3'b000;
        chk("x0_wen", rf_WEN, 1'b0);
        req_valid = 3'b011;
        #1;
        chk("x0_ptr_adv", req_ready, 3'b001);
        req_valid = 3'b000;

        // Reset mid-operation
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("mr_busy2_set", busy2, 1'b1);
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        chk("mr_wen_on", rf_WEN, 1'b1);
        nRST      = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("mr_wen_drop",  rf_WEN,    1'b0);
        chk("mr_busy2_clr", busy2,     1'b0);
        chk("mr_ready_off", req_ready, 3'b000);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("mr_restart0", req_ready, 3'b001);
        req_valid = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
